// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : Machine-mode CSR file with trap entry/return, interrupt
//               pending logic and 64-bit cycle/instret counters.
// Revision    : 1.0
// ============================================================================
module csr_unit #(
    parameter int          XLEN      = 32,
    parameter logic [63:0] MTVEC_RST = 64'h0,
    parameter bit          VECTORED  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_ren_i,
    input  logic [11:0]     csr_ridx_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_widx_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic [1:0]      csr_op_i,
    output logic            csr_illegal_o,
    input  logic            int_soft_i,
    input  logic            int_time_i,
    input  logic            int_exte_i,
    input  logic            trap_en_i,
    input  logic            trap_int_i,
    input  logic [3:0]      trap_code_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            instret_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] csr_mepc_o,
    output logic            csr_mstatus_mie_o
);

    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mscratch  = 12'h340;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;
    localparam logic [11:0] c_mtval     = 12'h343;
    localparam logic [11:0] c_mip       = 12'h344;
    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstreth = 12'hB82;
    localparam logic [11:0] c_cycle     = 12'hC00;
    localparam logic [11:0] c_instret   = 12'hC02;
    localparam logic [11:0] c_cycleh    = 12'hC80;
    localparam logic [11:0] c_instreth  = 12'hC82;

    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);
    localparam logic [63:0]     c_lo_mask    = (XLEN == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    localparam logic [XLEN-1:0] c_mtvec_rst  =
        {MTVEC_RST[XLEN-1:2], (VECTORED ? MTVEC_RST[1:0] : 2'b00)};

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;          // {MEIE, MTIE, MSIE}
    logic [2:0]      mip_q, mip_d;          // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic            mcause_int_q, mcause_int_d;
    logic [3:0]      mcause_code_q, mcause_code_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] w_wold;
    logic [XLEN-1:0] w_wval;
    logic [XLEN-1:0] w_tvec_base;
    logic            w_wr_req;
    logic            w_wr_legal;
    logic            w_wr_ok;
    logic            w_ctx_busy;

    function automatic logic csr_exists(input logic [11:0] idx);
        case (idx)
            c_mstatus, c_mie, c_mtvec, c_mscratch, c_mepc, c_mcause, c_mtval,
            c_mip, c_mcycle, c_minstret, c_cycle, c_instret:
                csr_exists = 1'b1;
            c_mcycleh, c_minstreth, c_cycleh, c_instreth:
                csr_exists = (XLEN == 32);
            default:
                csr_exists = 1'b0;
        endcase
    endfunction

    function automatic logic csr_read_only(input logic [11:0] idx);
        csr_read_only = (idx == c_mip) || (idx[11:8] == 4'hC);
    endfunction

    // Architectural view of each CSR; upper-half counter indices only exist for RV32.
    function automatic logic [XLEN-1:0] csr_value(input logic [11:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        case (idx)
            c_mstatus: begin
                v[3]     = mstatus_mie_q;
                v[7]     = mstatus_mpie_q;
                v[12:11] = 2'b11;
            end
            c_mie: begin
                v[3]  = mie_q[0];
                v[7]  = mie_q[1];
                v[11] = mie_q[2];
            end
            c_mip: begin
                v[3]  = mip_q[0];
                v[7]  = mip_q[1];
                v[11] = mip_q[2];
            end
            c_mtvec:    v = mtvec_q;
            c_mscratch: v = mscratch_q;
            c_mepc:     v = mepc_q;
            c_mcause: begin
                v[XLEN-1] = mcause_int_q;
                v[3:0]    = mcause_code_q;
            end
            c_mtval:               v = mtval_q;
            c_mcycle, c_cycle:     v = mcycle_q[XLEN-1:0];
            c_minstret, c_instret: v = minstret_q[XLEN-1:0];
            c_mcycleh, c_cycleh: begin
                if (XLEN == 32) v = XLEN'(mcycle_q[63:32]);
            end
            c_minstreth, c_instreth: begin
                if (XLEN == 32) v = XLEN'(minstret_q[63:32]);
            end
            default: v = '0;
        endcase
        csr_value = v;
    endfunction

    always_comb begin
        csr_rdata_o = '0;
        if (csr_ren_i && csr_exists(csr_ridx_i)) begin
            csr_rdata_o = csr_value(csr_ridx_i);
        end
    end

    always_comb begin
        w_wold = csr_value(csr_widx_i);
        case (csr_op_i)
            2'b01:   w_wval = csr_wdata_i;
            2'b10:   w_wval = w_wold | csr_wdata_i;
            2'b11:   w_wval = w_wold & ~csr_wdata_i;
            default: w_wval = w_wold;
        endcase
    end

    assign w_wr_req      = csr_wen_i && (csr_op_i != 2'b00);
    assign w_wr_legal    = csr_exists(csr_widx_i) && !csr_read_only(csr_widx_i);
    assign w_wr_ok       = w_wr_req && w_wr_legal;
    assign w_ctx_busy    = trap_en_i || mret_i;
    assign csr_illegal_o = (csr_ren_i && !csr_exists(csr_ridx_i)) || (w_wr_req && !w_wr_legal);

    assign irq_pending_o     = mstatus_mie_q && (|(mip_q & mie_q));
    assign csr_mepc_o        = mepc_q;
    assign csr_mstatus_mie_o = mstatus_mie_q;

    assign w_tvec_base   = mtvec_q & c_align_mask;
    assign trap_vector_o = ((mtvec_q[1:0] == 2'b01) && trap_int_i)
                         ? (w_tvec_base + XLEN'({trap_code_i, 2'b00}))
                         : w_tvec_base;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mip_d          = {int_exte_i, int_time_i, int_soft_i};
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, instret_i};

        // Trap-context CSRs yield to a coinciding trap or mret; the rest always commit.
        if (w_wr_ok) begin
            case (csr_widx_i)
                c_mstatus: begin
                    if (!w_ctx_busy) begin
                        mstatus_mie_d  = w_wval[3];
                        mstatus_mpie_d = w_wval[7];
                    end
                end
                c_mie:      mie_d = {w_wval[11], w_wval[7], w_wval[3]};
                c_mtvec:    mtvec_d = {w_wval[XLEN-1:2],
                                       ((VECTORED && (w_wval[1:0] == 2'b01)) ? 2'b01 : 2'b00)};
                c_mscratch: mscratch_d = w_wval;
                c_mepc: begin
                    if (!w_ctx_busy) mepc_d = w_wval & c_align_mask;
                end
                c_mcause: begin
                    if (!w_ctx_busy) begin
                        mcause_int_d  = w_wval[XLEN-1];
                        mcause_code_d = w_wval[3:0];
                    end
                end
                c_mtval: begin
                    if (!w_ctx_busy) mtval_d = w_wval;
                end
                c_mcycle:    mcycle_d   = (mcycle_q & ~c_lo_mask) | (64'(w_wval) & c_lo_mask);
                c_mcycleh:   mcycle_d   = {w_wval[31:0], mcycle_q[31:0]};
                c_minstret:  minstret_d = (minstret_q & ~c_lo_mask) | (64'(w_wval) & c_lo_mask);
                c_minstreth: minstret_d = {w_wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end

        if (trap_en_i) begin
            mepc_d         = trap_epc_i & c_align_mask;
            mcause_int_d   = trap_int_i;
            mcause_code_d  = trap_code_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= c_mtvec_rst;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Scoreboard bench for csr_unit (XLEN=32) with a word-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0
// ============================================================================
module tb_csr_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            csr_ren_i;
    logic [11:0]     csr_ridx_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_wen_i;
    logic [11:0]     csr_widx_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [1:0]      csr_op_i;
    logic            csr_illegal_o;
    logic            int_soft_i, int_time_i, int_exte_i;
    logic            trap_en_i, trap_int_i;
    logic [3:0]      trap_code_i;
    logic [XLEN-1:0] trap_epc_i, trap_tval_i;
    logic            mret_i, instret_i;
    logic            irq_pending_o;
    logic [XLEN-1:0] trap_vector_o;
    logic [XLEN-1:0] csr_mepc_o;
    logic            csr_mstatus_mie_o;

    csr_unit #(.XLEN(XLEN), .MTVEC_RST(64'h0), .VECTORED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .csr_ren_i(csr_ren_i), .csr_ridx_i(csr_ridx_i), .csr_rdata_o(csr_rdata_o),
        .csr_wen_i(csr_wen_i), .csr_widx_i(csr_widx_i), .csr_wdata_i(csr_wdata_i),
        .csr_op_i(csr_op_i), .csr_illegal_o(csr_illegal_o),
        .int_soft_i(int_soft_i), .int_time_i(int_time_i), .int_exte_i(int_exte_i),
        .trap_en_i(trap_en_i), .trap_int_i(trap_int_i), .trap_code_i(trap_code_i),
        .trap_epc_i(trap_epc_i), .trap_tval_i(trap_tval_i),
        .mret_i(mret_i), .instret_i(instret_i),
        .irq_pending_o(irq_pending_o), .trap_vector_o(trap_vector_o),
        .csr_mepc_o(csr_mepc_o), .csr_mstatus_mie_o(csr_mstatus_mie_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: CSRs held as architectural 32-bit words.
    bit [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit [63:0] m_cyc, m_ins;

    function automatic bit m_impl(input bit [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ro(input bit [11:0] a);
        return (a == 12'h344) || (a[11:8] == 4'hC);
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mip = 0; m_mtvec = 0;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_edge();
        bit [31:0] old, wv, st, mie_n, tv, scr, epc, cause, tval;
        bit [63:0] cyc, ins;
        bit        wr_ok, busy;
        old   = m_read(csr_widx_i);
        wr_ok = csr_wen_i && (csr_op_i != 0) && m_impl(csr_widx_i) && !m_ro(csr_widx_i);
        case (csr_op_i)
            2'b01:   wv = csr_wdata_i;
            2'b10:   wv = old | csr_wdata_i;
            default: wv = old & ~csr_wdata_i;
        endcase
        busy = trap_en_i || mret_i;
        st = m_mstatus; mie_n = m_mie; tv = m_mtvec; scr = m_mscratch;
        epc = m_mepc; cause = m_mcause; tval = m_mtval;
        cyc = m_cyc + 1;
        ins = m_ins + 64'(instret_i);
        if (wr_ok) begin
            case (csr_widx_i)
                12'h300: if (!busy) st = (wv & 32'h88) | 32'h1800;
                12'h304: mie_n = wv & 32'h888;
                12'h305: tv = wv[1] ? (wv & ~32'h3) : wv;
                12'h340: scr = wv;
                12'h341: if (!busy) epc = wv & ~32'h3;
                12'h342: if (!busy) cause = wv & 32'h8000_000F;
                12'h343: if (!busy) tval = wv;
                12'hB00: cyc = {m_cyc[63:32], wv};
                12'hB80: cyc = {wv, m_cyc[31:0]};
                12'hB02: ins = {m_ins[63:32], wv};
                12'hB82: ins = {wv, m_ins[31:0]};
                default: ;
            endcase
        end
        if (trap_en_i) begin
            epc   = trap_epc_i & ~32'h3;
            cause = {trap_int_i, 27'd0, trap_code_i};
            tval  = trap_tval_i;
            st    = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mret_i) begin
            st = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end
        m_mstatus = st; m_mie = mie_n; m_mtvec = tv; m_mscratch = scr;
        m_mepc = epc; m_mcause = cause; m_mtval = tval; m_cyc = cyc; m_ins = ins;
        m_mip = (int_exte_i ? 32'h800 : 0) | (int_time_i ? 32'h80 : 0) | (int_soft_i ? 32'h8 : 0);
    endtask

    typedef struct {
        bit [31:0] rdata;
        bit        ill;
        bit        irq;
        bit [31:0] vec;
        bit [31:0] mepc;
        bit        mie;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model_out();
        exp_t e;
        bit [31:0] base;
        e.rdata = (csr_ren_i && m_impl(csr_ridx_i)) ? m_read(csr_ridx_i) : 32'h0;
        e.ill   = (csr_ren_i && !m_impl(csr_ridx_i)) ||
                  (csr_wen_i && (csr_op_i != 0) && (!m_impl(csr_widx_i) || m_ro(csr_widx_i)));
        e.irq   = m_mstatus[3] && ((m_mip & m_mie) != 0);
        base    = m_mtvec & ~32'h3;
        e.vec   = ((m_mtvec[1:0] == 2'b01) && trap_int_i) ? base + 32'(trap_code_i) * 4 : base;
        e.mepc  = m_mepc;
        e.mie   = m_mstatus[3];
        return e;
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle against live outputs.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_rdata",   64'(csr_rdata_o),       64'(e.rdata));
            check("sb_illegal", 64'(csr_illegal_o),     64'(e.ill));
            check("sb_irq",     64'(irq_pending_o),     64'(e.irq));
            check("sb_vector",  64'(trap_vector_o),     64'(e.vec));
            check("sb_mepc",    64'(csr_mepc_o),        64'(e.mepc));
            check("sb_mie",     64'(csr_mstatus_mie_o), 64'(e.mie));
        end
    end

    task automatic idle();
        csr_ren_i = 0; csr_ridx_i = 0; csr_wen_i = 0; csr_widx_i = 0;
        csr_wdata_i = 0; csr_op_i = 0; int_soft_i = 0; int_time_i = 0; int_exte_i = 0;
        trap_en_i = 0; trap_int_i = 0; trap_code_i = 0; trap_epc_i = 0; trap_tval_i = 0;
        mret_i = 0; instret_i = 0;
    endtask

    // Called one time unit after a rising edge; returns one unit after the next one.
    task automatic step();
        #1;
        if (rst) model_reset();
        sb_q.push_back(model_out());
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic wr(input bit [11:0] a, input bit [1:0] op, input bit [31:0] d);
        idle();
        csr_wen_i = 1; csr_widx_i = a; csr_op_i = op; csr_wdata_i = d;
        step();
    endtask

    task automatic rd_check(input string name, input bit [11:0] a, input bit [31:0] exp);
        idle();
        csr_ren_i = 1; csr_ridx_i = a;
        #1;
        check(name, 64'(csr_rdata_o), 64'(exp));
        step();
    endtask

    bit [11:0] idx_tab [0:18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                  12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h7FF, 12'h301, 12'hB01};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        model_reset();
        @(posedge clk); #1;
        rd_check("rst_mstatus", 12'h300, 32'h1800);
        rd_check("rst_mtvec",   12'h305, 32'h0);
        rst = 0;
        step();

        // Timer interrupt path
        wr(12'h304, 2'b01, 32'h888);
        wr(12'h300, 2'b10, 32'h8);
        idle(); int_time_i = 1; step();
        idle(); csr_ren_i = 1; csr_ridx_i = 12'h344;
        #1;
        check("mip_time", 64'(csr_rdata_o), 64'h80);
        check("irq_pending", 64'(irq_pending_o), 64'h1);
        step();

        // Vectored trap entry
        wr(12'h305, 2'b01, 32'h1001);
        idle(); trap_en_i = 1; trap_int_i = 1; trap_code_i = 4'd7;
        trap_epc_i = 32'h203; trap_tval_i = 32'hDEAD;
        #1;
        check("trap_vector", 64'(trap_vector_o), 64'h101C);
        step();
        check("mie_after_trap", 64'(csr_mstatus_mie_o), 64'h0);
        rd_check("mepc_trap",    12'h341, 32'h200);
        rd_check("mcause_trap",  12'h342, 32'h8000_0007);
        rd_check("mstatus_trap", 12'h300, 32'h1880);

        idle(); mret_i = 1; step();
        rd_check("mstatus_mret", 12'h300, 32'h1888);

        // Counter carry across halves
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b01, 32'h0);
        idle(); step(); step();
        csr_ren_i = 1; csr_ridx_i = 12'hB80;
        #1; check("mcycleh_carry", 64'(csr_rdata_o), 64'h1);
        csr_ridx_i = 12'hB00;
        #1; check("mcycle_carry", 64'(csr_rdata_o), 64'h1);
        step();

        // Trap vs coinciding CSR writes
        idle(); csr_wen_i = 1; csr_widx_i = 12'h341; csr_op_i = 2'b01; csr_wdata_i = 32'h500;
        trap_en_i = 1; trap_epc_i = 32'h1236;
        step();
        rd_check("mepc_trap_wins", 12'h341, 32'h1234);
        idle(); csr_wen_i = 1; csr_widx_i = 12'h340; csr_op_i = 2'b01; csr_wdata_i = 32'hCAFE;
        trap_en_i = 1; trap_epc_i = 32'h1234;
        step();
        rd_check("mscratch_commit", 12'h340, 32'hCAFE);

        // Illegal accesses
        idle(); csr_wen_i = 1; csr_widx_i = 12'hC00; csr_op_i = 2'b01; csr_wdata_i = 32'h5;
        #1; check("illegal_c00", 64'(csr_illegal_o), 64'h1);
        step();
        idle(); csr_wen_i = 1; csr_widx_i = 12'h7FF; csr_op_i = 2'b01; csr_wdata_i = 32'h1;
        csr_ren_i = 1; csr_ridx_i = 12'h7FF;
        #1;
        check("illegal_7ff", 64'(csr_illegal_o), 64'h1);
        check("rdata_7ff", 64'(csr_rdata_o), 64'h0);
        step();
        wr(12'h344, 2'b10, 32'h888);
        rd_check("mip_ro", 12'h344, 32'h0);
        rd_check("mscratch_kept", 12'h340, 32'hCAFE);

        // Async reset mid-trap
        wr(12'h300, 2'b10, 32'h8);
        wr(12'h304, 2'b01, 32'h8);
        idle(); int_soft_i = 1; step();
        idle(); int_soft_i = 1;
        #1; check("irq_before_rst", 64'(irq_pending_o), 64'h1);
        trap_en_i = 1; trap_epc_i = 32'h4444; rst = 1;
        csr_ren_i = 1; csr_ridx_i = 12'h305;
        #1;
        check("rst_irq",   64'(irq_pending_o),     64'h0);
        check("rst_mie_o", 64'(csr_mstatus_mie_o), 64'h0);
        check("rst_mepc",  64'(csr_mepc_o),        64'h0);
        check("rst_mtvec_async", 64'(csr_rdata_o), 64'h0);
        step();
        idle(); rst = 0; step();
        rd_check("mepc_post_rst",     12'h341, 32'h0);
        rd_check("mscratch_post_rst", 12'h340, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            idle();
            csr_ren_i   = $urandom_range(0, 1);
            csr_ridx_i  = idx_tab[$urandom_range(0, 18)];
            csr_wen_i   = ($urandom_range(0, 2) == 0);
            csr_widx_i  = idx_tab[$urandom_range(0, 18)];
            csr_op_i    = 2'($urandom_range(0, 3));
            csr_wdata_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            int_soft_i  = $urandom_range(0, 1);
            int_time_i  = $urandom_range(0, 1);
            int_exte_i  = $urandom_range(0, 1);
            trap_en_i   = ($urandom_range(0, 9) == 0);
            trap_int_i  = $urandom_range(0, 1);
            trap_code_i = 4'($urandom_range(0, 15));
            trap_epc_i  = $urandom;
            trap_tval_i = $urandom;
            mret_i      = ($urandom_range(0, 9) == 0);
            instret_i   = $urandom_range(0, 1);
            step();
        end

        idle();
        step();
        @(negedge clk); #1;
        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning data width of every CSR and data port; the only legal values are 32 and 64.
REQ-002 Parameter MTVEC_RST, default 0, meaning the reset value of mtvec.
REQ-003 Parameter VECTORED, default 1, meaning vectored mtvec mode is supported; when 0, mtvec[1:0] is forced to 0.
REQ-004 Port list (name, direction, width, meaning), in the order below, SHALL be:
  - clk  in  1  clock.
  - rst  in  1  asynchronous reset, active-high.
  - csr_ren_i  in  1  read strobe.
  - csr_ridx_i  in  12  read address.
  - csr_rdata_o  out  XLEN  read data.
  - csr_wen_i  in  1  write strobe.
  - csr_widx_i  in  12  write address.
  - csr_wdata_i  in  XLEN  write operand.
  - csr_op_i  in  2  write operation: 01 write, 10 set, 11 clear, 00 no write.
  - csr_illegal_o  out  1  the access is illegal.
  - int_soft_i, int_time_i, int_exte_i  in  1 each  interrupt levels.
  - trap_en_i  in  1  trap entry this cycle.
  - trap_int_i  in  1  the trap is an interrupt.
  - trap_code_i  in  4  cause code.
  - trap_epc_i  in  XLEN  return PC.
  - trap_tval_i  in  XLEN  trap value.
  - mret_i  in  1  trap return this cycle.
  - instret_i  in  1  one instruction retired.
  - irq_pending_o  out  1  enabled interrupt pending.
  - trap_vector_o  out  XLEN  trap handler entry address.
  - csr_mepc_o  out  XLEN  current mepc.
  - csr_mstatus_mie_o  out  1  global interrupt enable.

Function
REQ-005 The implemented CSR map SHALL be:
  - mstatus 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 0x304: bits 3, 7 and 11 are writable; all others read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341, with bits [1:0] reading 0.
  - mcause 0x342: bit XLEN-1 is the interrupt flag, bits [3:0] are the code, all other bits are 0.
  - mtval 0x343.
  - mip 0x344, read-only: MSIP bit 3, MTIP bit 7, MEIP bit 11.
  - mcycle 0xB00 and minstret 0xB02; both counters are 64-bit.
  - mcycleh 0xB80 and minstreth 0xB82, present only when XLEN=32.
  - cycle 0xC00 and instret 0xC02 (plus 0xC80 and 0xC82 when XLEN=32), read-only shadows of the counters.
REQ-006 Reads SHALL be combinational; csr_rdata_o SHALL be 0 when csr_ren_i=0 or the index is unimplemented.
REQ-007 Writes SHALL commit at the clk edge; the new value SHALL be old OR operand for set and old AND NOT operand for clear.
REQ-008 csr_illegal_o SHALL be combinational and asserted when any of the following holds:
  - read of an unimplemented index;
  - write (op≠00) to an unimplemented index;
  - write (op≠00) to a read-only index (0x344, 0xC00–0xC82).
  An illegal write SHALL change no state.
REQ-009 int_*_i SHALL be registered once into mip, giving 1-cycle latency; software writes SHALL NOT affect mip.
REQ-010 irq_pending_o SHALL equal mstatus.MIE AND |(mip AND mie), combinational from registered state.
REQ-011 On trap_en_i=1 the following SHALL update in one edge:
  - mepc ← trap_epc_i with bits [1:0] cleared;
  - mcause ← {trap_int_i, zeros, trap_code_i};
  - mtval ← trap_tval_i;
  - MPIE ← MIE;
  - MIE ← 0.
REQ-012 On mret_i=1 (with trap_en_i=0), MIE ← MPIE and MPIE ← 1.
REQ-013 Same-cycle priority SHALL be trap_en_i > mret_i > CSR write.
  - A CSR write to mstatus, mepc, mcause or mtval that coincides with trap or mret SHALL be dropped.
  - A coinciding CSR write to any other CSR SHALL commit.
REQ-014 trap_vector_o SHALL be combinational:
  - {mtvec[XLEN-1:2],2'b00} when mtvec[1:0]=00, or when trap_int_i=0;
  - base + 4×trap_code_i when mtvec[1:0]=01 and trap_int_i=1.
  A written mtvec mode of 1x SHALL be stored as 00.
REQ-015 Counter behaviour:
  - mcycle SHALL increment by 1 every cycle.
  - minstret SHALL increment by 1 on each cycle with instret_i=1.
  - Both counters SHALL wrap from all-ones to 0.
REQ-016 A CSR write to any half of a counter SHALL replace that half with the written value and suppress the increment for the whole 64-bit counter in that cycle; the other half SHALL hold.
REQ-017 csr_mepc_o and csr_mstatus_mie_o SHALL reflect register state with no combinational path from the inputs.

Reset
REQ-018 While rst=1, the following SHALL hold asynchronously, independent of clk:
  - mtvec = MTVEC_RST;
  - mstatus MIE=0 and MPIE=0;
  - mie, mip, mscratch, mepc, mcause, mtval, mcycle and minstret all 0;
  - irq_pending_o=0 and csr_mstatus_mie_o=0.
REQ-019 Reset asserted mid-trap SHALL discard the trap update; the first edge after rst deasserts SHALL resume normal operation.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
  - Write mie=0x888 and set mstatus=0x8, then pulse int_time_i → mip reads 0x80 one cycle later and irq_pending_o=1.
  - mtvec=0x1001, trap_en_i with int=1, code=7, epc=0x203 → trap_vector_o=0x101C; then mepc=0x200, mcause=0x80000007, MIE=0, MPIE=1.
  - mret_i after the previous scenario → MIE=1, MPIE=1.
  - XLEN=32, write mcycle=0xFFFFFFFF, mcycleh=0 → two cycles later mcycleh=1 and mcycle=0x00000001.
  - trap_en_i coincides with a write of mepc=0x500 → mepc=trap_epc_i; with a coinciding mscratch write, mscratch updates.
  - Write to 0xC00 or 0x7FF → csr_illegal_o=1 and no state change; assert rst mid-run → all values per REQ-018.
